// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the multicycle LEGv8 main control FSM.
// Opcode constants, ALU-op / ALU-src-B codes, state enum, control bundle.
package legv8_ctrl_pkg;

  localparam int OPC_W = 11;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [7:0] OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0] OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CBZ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_DOFS = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    LOAD_RD  = 4'd3,
    LOAD_WB  = 4'd4,
    STORE    = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    CBZ      = 4'd8,
    BR       = 4'd9,
    TRAP     = 4'd10
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg2loc;
    logic       instr_done;
    logic       mem_err;
  } ctrl_t;

  // States that wait on mem_ready and are subject to the timeout.
  function automatic logic is_wait_state(state_e s);
    return (s == FETCH) || (s == LOAD_RD) || (s == STORE);
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier for the LEGv8 main control FSM.
// Splits IR[31:21] into mem/load/R-type/CBZ/B/illegal classes.
import legv8_ctrl_pkg::*;

module legv8_opcode_class (
  input  logic [OPC_W-1:0] opcode_i,
  output logic             is_mem_o,
  output logic             is_load_o,
  output logic             is_r_o,
  output logic             is_cbz_o,
  output logic             is_b_o,
  output logic             is_illegal_o
);

  logic ld, st, r, cbz, b;

  assign ld  = (opcode_i == OP_LDUR);
  assign st  = (opcode_i == OP_STUR);
  assign r   = (opcode_i == OP_ADD) |
               (opcode_i == OP_SUB) |
               (opcode_i == OP_AND) |
               (opcode_i == OP_ORR);
  assign cbz = (opcode_i[10:3] == OP_CBZ_PFX);
  assign b   = (opcode_i[10:5] == OP_B_PFX);

  assign is_mem_o     = ld | st;
  assign is_load_o    = ld;
  assign is_r_o       = r;
  assign is_cbz_o     = cbz;
  assign is_b_o       = b;
  assign is_illegal_o = ~(ld | st | r | cbz | b);

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath with memory timeout.
// Define ILLEGAL_TRAP_EN to trap undecoded opcodes (else they act as NOPs).
import legv8_ctrl_pkg::*;

module legv8_multicycle_ctrl #(
  parameter int OPCODE_W    = 11,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic [1:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                reg2loc,
  output logic                instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic                mem_err
);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic is_mem, is_load, is_r;
  logic is_cbz, is_b, is_ill;
  logic wait_st, tmo;
  ctrl_t c, g;

  legv8_opcode_class u_cls (
    .opcode_i     (opcode),
    .is_mem_o     (is_mem),
    .is_load_o    (is_load),
    .is_r_o       (is_r),
    .is_cbz_o     (is_cbz),
    .is_b_o       (is_b),
    .is_illegal_o (is_ill)
  );

  assign wait_st = is_wait_state(state_q);
  assign tmo     = wait_st & ~mem_ready &
                   (cnt_q == TMO_W'(MEM_TIMEOUT));

  // Wait counter: counts stalled cycles, cleared on progress or abort.
  always_comb begin
    cnt_d = '0;
    if (wait_st && !mem_ready && !tmo)
      cnt_d = cnt_q + TMO_W'(1);
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (tmo)            state_d = FETCH;
        else if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        if (is_mem)      state_d = MEM_ADDR;
        else if (is_r)   state_d = R_EXEC;
        else if (is_cbz) state_d = CBZ;
        else if (is_b)   state_d = BR;
`ifdef ILLEGAL_TRAP_EN
        else             state_d = TRAP;
`else
        else             state_d = FETCH;
`endif
      end
      MEM_ADDR: state_d = is_load ? LOAD_RD : STORE;
      LOAD_RD: begin
        if (tmo)            state_d = FETCH;
        else if (mem_ready) state_d = LOAD_WB;
      end
      LOAD_WB: state_d = FETCH;
      STORE: begin
        if (tmo || mem_ready) state_d = FETCH;
      end
      R_EXEC:  state_d = R_WB;
      R_WB:    state_d = FETCH;
      CBZ:     state_d = FETCH;
      BR:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode; a few enables qualified by mem_ready/zero.
  always_comb begin
    c = '0;
    unique case (state_q)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_MEM;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      DECODE: begin
        c.alu_src_b = SRCB_BOFS;
        c.alu_op    = ALUOP_MEM;
        c.reg2loc   = (is_mem & ~is_load) | is_cbz;
`ifndef ILLEGAL_TRAP_EN
        c.instr_done = is_ill;
`endif
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_DOFS;
        c.alu_op    = ALUOP_MEM;
      end
      LOAD_RD: c.mem_read = 1'b1;
      LOAD_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      STORE: begin
        c.mem_write  = 1'b1;
        c.reg2loc    = 1'b1;
        c.instr_done = mem_ready;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_R;
      end
      R_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      CBZ: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_REG;
        c.alu_op     = ALUOP_CBZ;
        c.reg2loc    = 1'b1;
        c.pc_src     = 1'b1;
        c.pc_write   = zero;
        c.instr_done = 1'b1;
      end
      BR: begin
        c.pc_src     = 1'b1;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: ;
    endcase
    c.mem_err = tmo;
  end

  // Reset forces every output low without waiting for a clock.
  assign g = rst_n ? c : '0;

  assign alu_op     = g.alu_op;
  assign alu_src_a  = g.alu_src_a;
  assign alu_src_b  = g.alu_src_b;
  assign pc_write   = g.pc_write;
  assign pc_src     = g.pc_src;
  assign ir_write   = g.ir_write;
  assign mem_read   = g.mem_read;
  assign mem_write  = g.mem_write;
  assign mem_to_reg = g.mem_to_reg;
  assign reg_write  = g.reg_write;
  assign reg2loc    = g.reg2loc;
  assign instr_done = g.instr_done;
  assign mem_err    = g.mem_err;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = rst_n & (state_q == TRAP);
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl.
// Directed per-cycle vectors; a negedge monitor pops and compares.
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, pc_src, ir_write;
  logic        mem_read, mem_write, mem_to_reg;
  logic        reg_write, reg2loc, instr_done;
  logic        mem_err;
  logic        ill_w;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .reg2loc    (reg2loc),
    .instr_done (instr_done),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op (ill_w),
`endif
    .mem_err    (mem_err)
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill_w = 1'b0;
`endif

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZI = 11'b10110100101;
  localparam logic [10:0] BI   = 11'b00010100110;
  localparam logic [10:0] BAD  = 11'b11111111111;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] mk(
    input logic [1:0] aop, input logic sa,
    input logic [1:0] sb,  input logic pw,
    input logic ps,  input logic irw,
    input logic mr,  input logic mw,
    input logic m2r, input logic rw,
    input logic r2l, input logic dn,
    input logic er,  input logic il);
    return {aop, sa, sb, pw, ps, irw, mr,
            mw, m2r, rw, r2l, dn, er, il};
  endfunction

  logic [15:0] E0, EF1, EF0, EFT, ED, ED2, EDN;
  logic [15:0] EMA, ELR, ELW, ES0, ES1, EST;
  logic [15:0] ERE, ERW, EC1, EC0, EBR, ETR;

  logic [15:0] act;
  assign act = {alu_op, alu_src_a, alu_src_b,
                pc_write, pc_src, ir_write, mem_read,
                mem_write, mem_to_reg, reg_write,
                reg2loc, instr_done, mem_err, ill_w};

  // Monitor: one expected vector per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      n_cmp++;
      if (act !== x.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b",
                 x.nm, act, x.v);
      end
    end
  end

  task automatic step(input logic r,
                      input logic [10:0] op,
                      input logic mr, input logic z,
                      input logic [15:0] e,
                      input string nm);
    exp_t x;
    rst_n     = r;
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    x.v  = e;
    x.nm = nm;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //       aop   sa sb    pw ps irw mr mw m2r rw r2l dn er il
    E0  = mk(2'b00,0,2'b00, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    EF1 = mk(2'b00,0,2'b01, 1, 0, 1,  1, 0, 0,  0, 0,  0, 0, 0);
    EF0 = mk(2'b00,0,2'b01, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0);
    EFT = mk(2'b00,0,2'b01, 0, 0, 0,  1, 0, 0,  0, 0,  0, 1, 0);
    ED  = mk(2'b00,0,2'b11, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    ED2 = mk(2'b00,0,2'b11, 0, 0, 0,  0, 0, 0,  0, 1,  0, 0, 0);
    EDN = mk(2'b00,0,2'b11, 0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0);
    EMA = mk(2'b00,1,2'b10, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    ELR = mk(2'b00,0,2'b00, 0, 0, 0,  1, 0, 0,  0, 0,  0, 0, 0);
    ELW = mk(2'b00,0,2'b00, 0, 0, 0,  0, 0, 1,  1, 0,  1, 0, 0);
    ES0 = mk(2'b00,0,2'b00, 0, 0, 0,  0, 1, 0,  0, 1,  0, 0, 0);
    ES1 = mk(2'b00,0,2'b00, 0, 0, 0,  0, 1, 0,  0, 1,  1, 0, 0);
    EST = mk(2'b00,0,2'b00, 0, 0, 0,  0, 1, 0,  0, 1,  0, 1, 0);
    ERE = mk(2'b10,1,2'b00, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    ERW = mk(2'b00,0,2'b00, 0, 0, 0,  0, 0, 0,  1, 0,  1, 0, 0);
    EC1 = mk(2'b01,1,2'b00, 1, 1, 0,  0, 0, 0,  0, 1,  1, 0, 0);
    EC0 = mk(2'b01,1,2'b00, 0, 1, 0,  0, 0, 0,  0, 1,  1, 0, 0);
    EBR = mk(2'b00,0,2'b00, 1, 1, 0,  0, 0, 0,  0, 0,  1, 0, 0);
    ETR = mk(2'b00,0,2'b00, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 1);

    @(posedge clk);
    #1;

    step(0, ADD, 1, 0, E0, "reset0");
    step(0, ADD, 1, 0, E0, "reset1");

    step(1, ADD, 1, 0, EF1, "add_fetch");
    step(1, ADD, 1, 0, ED,  "add_decode");
    step(1, ADD, 1, 0, ERE, "add_exec");
    step(1, ADD, 1, 0, ERW, "add_wb");

    step(1, ORR, 1, 0, EF1, "orr_fetch");
    step(1, ORR, 1, 0, ED,  "orr_decode");
    step(1, ORR, 1, 0, ERE, "orr_exec");
    step(1, ORR, 1, 0, ERW, "orr_wb");

    step(1, LDUR, 1, 0, EF1, "ld_fetch");
    step(1, LDUR, 1, 0, ED,  "ld_decode");
    step(1, LDUR, 1, 0, EMA, "ld_addr");
    for (int i = 0; i < 3; i++)
      step(1, LDUR, 0, 0, ELR, "ld_wait");
    step(1, LDUR, 1, 0, ELR, "ld_read");
    step(1, LDUR, 1, 0, ELW, "ld_wb");

    step(1, CBZI, 1, 1, EF1, "cbz1_fetch");
    step(1, CBZI, 1, 1, ED2, "cbz1_decode");
    step(1, CBZI, 1, 1, EC1, "cbz_taken");
    step(1, CBZI, 1, 0, EF1, "cbz0_fetch");
    step(1, CBZI, 1, 0, ED2, "cbz0_decode");
    step(1, CBZI, 1, 0, EC0, "cbz_not_taken");

    step(1, BI, 1, 0, EF1, "b_fetch");
    step(1, BI, 1, 0, ED,  "b_decode");
    step(1, BI, 1, 0, EBR, "b_branch");

    step(1, STUR, 1, 0, EF1, "st_fetch");
    step(1, STUR, 1, 0, ED2, "st_decode");
    step(1, STUR, 1, 0, EMA, "st_addr");
    step(1, STUR, 1, 0, ES1, "st_done");

    step(1, STUR, 1, 0, EF1, "sto_fetch");
    step(1, STUR, 1, 0, ED2, "sto_decode");
    step(1, STUR, 1, 0, EMA, "sto_addr");
    for (int i = 0; i < 15; i++)
      step(1, STUR, 0, 0, ES0, "sto_wait");
    step(1, STUR, 0, 0, EST, "sto_timeout");
    step(1, STUR, 1, 0, EF1, "sto_after_fetch");

    step(1, STUR, 1, 0, ED2, "stl_decode");
    step(1, STUR, 1, 0, EMA, "stl_addr");
    for (int i = 0; i < 15; i++)
      step(1, STUR, 0, 0, ES0, "stl_wait");
    step(1, STUR, 1, 0, ES1, "stl_ready_at_limit");

    for (int i = 0; i < 15; i++)
      step(1, LDUR, 0, 0, EF0, "f_wait");
    step(1, LDUR, 0, 0, EFT, "f_timeout");
    step(1, LDUR, 0, 0, EF0, "f_retry");
    step(1, LDUR, 1, 0, EF1, "f_go");
    step(1, LDUR, 1, 0, ED,  "rl_decode");
    step(1, LDUR, 1, 0, EMA, "rl_addr");
    step(1, LDUR, 0, 0, ELR, "rl_wait");
    step(0, LDUR, 1, 0, E0,  "rl_reset_mid");
    step(0, LDUR, 1, 0, E0,  "rl_reset_hold");
    step(1, ADD,  1, 0, EF1, "rl_post_fetch");
    step(1, ADD,  1, 0, ED,  "rl_post_decode");
    step(1, ADD,  1, 0, ERE, "rl_post_exec");
    step(1, ADD,  1, 0, ERW, "rl_post_wb");

    step(1, BAD, 1, 0, EF1, "ill_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(1, BAD, 1, 0, ED,  "ill_decode");
    for (int i = 0; i < 3; i++)
      step(1, BAD, 1, 0, ETR, "ill_trap");
    step(0, BAD, 1, 0, E0,  "ill_reset");
    step(1, ADD, 1, 0, EF1, "ill_post_fetch");
`else
    step(1, BAD, 1, 0, EDN, "ill_nop_decode");
    step(1, ADD, 1, 0, EF1, "ill_next_fetch");
`endif

    for (int i = 0; i < 4 && sbq.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0",
               sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
